// File: rtl/dma_engine_if.sv
// rtl/dma_engine_if.sv - memory bus bundle between the DMA engine and the arbiter/memory side
interface dma_engine_if #(
  parameter int ADDR_W = 24
) ();
  logic              busReq;
  logic              busGrant;
  logic [1:0]        memReadWrite;
  logic [ADDR_W-1:0] addressLinesOut;
  logic [7:0]        dataBusIn;
  logic [7:0]        dataBusOut;

  modport master (
    output busReq,
    output memReadWrite,
    output addressLinesOut,
    output dataBusOut,
    input  busGrant,
    input  dataBusIn
  );

  modport slave (
    input  busReq,
    input  memReadWrite,
    input  addressLinesOut,
    input  dataBusOut,
    output busGrant,
    output dataBusIn
  );
endinterface

// File: rtl/dma_engine.sv
// rtl/dma_engine.sv - single-channel byte DMA: read one byte, write one byte, repeat
module dma_engine #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  dma_engine_if.master      bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    READ,
    WRITE,
    FINISH
  } state_t;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_IDLE  = 2'b11;

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] srcReg;
  logic [ADDR_W-1:0] dstReg;
  logic [LEN_W-1:0]  countReg;
  logic [7:0]        holdReg;

  // Parameters are latched only in IDLE, so a start while busy has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      srcReg   <= '0;
      dstReg   <= '0;
      countReg <= '0;
      holdReg  <= '0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state   <= nextState;
      done    <= (state == FINISH) && !abort;
      aborted <= (state != IDLE) && abort;
      case (state)
        IDLE: begin
          if (start) begin
            srcReg   <= srcAddr;
            dstReg   <= dstAddr;
            countReg <= length;
          end
        end
        READ: begin
          if (bus.busGrant && !abort) holdReg <= bus.dataBusIn;
        end
        WRITE: begin
          if (bus.busGrant && !abort) begin
            srcReg   <= srcReg + ADDR_W'(1);
            dstReg   <= dstReg + ADDR_W'(1);
            countReg <= countReg - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState           = state;
    bus.busReq          = 1'b0;
    bus.memReadWrite    = MODE_IDLE;
    bus.addressLinesOut = '0;
    bus.dataBusOut      = 8'h00;
    case (state)
      IDLE: begin
        if (start) nextState = (length == '0) ? FINISH : WAIT_GNT;
      end
      WAIT_GNT: begin
        bus.busReq = 1'b1;
        if (bus.busGrant) nextState = READ;
      end
      READ: begin
        bus.busReq          = 1'b1;
        bus.addressLinesOut = srcReg;
        if (bus.busGrant) begin
          bus.memReadWrite = MODE_READ;
          nextState        = WRITE;
        end
      end
      WRITE: begin
        bus.busReq          = 1'b1;
        bus.addressLinesOut = dstReg;
        bus.dataBusOut      = holdReg;
        if (bus.busGrant) begin
          bus.memReadWrite = MODE_WRITE;
          nextState        = (countReg == LEN_W'(1)) ? FINISH : READ;
        end
      end
      FINISH: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Abort outranks every other transition, including completion.
    if (abort && state != IDLE) nextState = IDLE;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dma_engine.sv
// tb/tb_dma_engine.sv - directed self-checking bench for dma_engine
module tb_dma_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        grant = 1'b1;
  logic [23:0] srcAddr = '0;
  logic [23:0] dstAddr = '0;
  logic [15:0] length = '0;
  logic        busy, done, aborted;
  int          checks = 0;
  int          errors = 0;

  dma_engine_if #(.ADDR_W(24)) bus ();

  // Memory model: each byte is its low address bits XOR 8'hA5.
  assign bus.busGrant  = grant;
  assign bus.dataBusIn = bus.addressLinesOut[7:0] ^ 8'hA5;

  dma_engine #(.ADDR_W(24), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .srcAddr(srcAddr), .dstAddr(dstAddr),
    .length(length), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [23:0] s, input logic [23:0] d, input logic [15:0] n);
    srcAddr = s; dstAddr = d; length = n; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1'b1;
      else cyc();
    end
    checkVal(tag, {31'd0, seen}, 32'd1);
    cyc();
  endtask

  task automatic checkIdle(input string tag);
    checkVal({tag, "_req"}, {31'd0, bus.busReq}, 32'd0);
    checkVal({tag, "_mode"}, {30'd0, bus.memReadWrite}, 32'd3);
  endtask

  initial begin
    cyc();
    cyc();
    rst = 1'b0;
    checkIdle("rst");
    checkVal("rst_addr", {8'd0, bus.addressLinesOut}, 32'd0);
    checkVal("rst_dout", {24'd0, bus.dataBusOut}, 32'd0);
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    checkVal("rst_done", {31'd0, done}, 32'd0);
    checkVal("rst_aborted", {31'd0, aborted}, 32'd0);

    // Three-byte copy, continuous grant.
    launch(24'h000100, 24'h002000, 16'd3);
    checkVal("s1_busy", {31'd0, busy}, 32'd1);
    checkVal("s1_wait_req", {31'd0, bus.busReq}, 32'd1);
    checkVal("s1_wait_mode", {30'd0, bus.memReadWrite}, 32'd3);
    cyc();
    for (int i = 0; i < 3; i++) begin
      checkVal("s1_rd_mode", {30'd0, bus.memReadWrite}, 32'd0);
      checkVal("s1_rd_addr", {8'd0, bus.addressLinesOut}, 32'h0100 + i);
      cyc();
      checkVal("s1_wr_mode", {30'd0, bus.memReadWrite}, 32'd2);
      checkVal("s1_wr_addr", {8'd0, bus.addressLinesOut}, 32'h2000 + i);
      checkVal("s1_wr_data", {24'd0, bus.dataBusOut}, 32'h00A5 ^ i);
      checkVal("s1_done_early", {31'd0, done}, 32'd0);
      cyc();
    end
    checkIdle("s1_finish");
    checkVal("s1_finish_busy", {31'd0, busy}, 32'd1);
    cyc();
    checkVal("s1_done", {31'd0, done}, 32'd1);
    checkVal("s1_busy_off", {31'd0, busy}, 32'd0);
    cyc();
    checkVal("s1_done_once", {31'd0, done}, 32'd0);

    // Zero length: straight to FINISH, done two cycles after start.
    launch(24'h000040, 24'h000080, 16'd0);
    checkIdle("s2_fin");
    checkVal("s2_done_early", {31'd0, done}, 32'd0);
    cyc();
    checkVal("s2_done", {31'd0, done}, 32'd1);
    checkIdle("s2_after");
    cyc();

    // Grant removed for three cycles during the second write.
    launch(24'h000010, 24'h000300, 16'd3);
    repeat (4) cyc();
    grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkVal("s3_stall_mode", {30'd0, bus.memReadWrite}, 32'd3);
      checkVal("s3_stall_req", {31'd0, bus.busReq}, 32'd1);
      checkVal("s3_stall_addr", {8'd0, bus.addressLinesOut}, 32'h0301);
      cyc();
    end
    grant = 1'b1;
    #1;
    checkVal("s3_res_mode", {30'd0, bus.memReadWrite}, 32'd2);
    checkVal("s3_res_addr", {8'd0, bus.addressLinesOut}, 32'h0301);
    checkVal("s3_res_data", {24'd0, bus.dataBusOut}, 32'h11 ^ 32'hA5);
    cyc();
    checkVal("s3_next_rd", {8'd0, bus.addressLinesOut}, 32'h0012);
    waitDone("s3_done");

    // Source address wraps at the top of the address space.
    launch(24'hFFFFFF, 24'h000400, 16'd2);
    cyc();
    checkVal("s4_rd0", {8'd0, bus.addressLinesOut}, 32'h00FFFFFF);
    cyc();
    checkVal("s4_wr0_data", {24'd0, bus.dataBusOut}, 32'h5A);
    cyc();
    checkVal("s4_rd1", {8'd0, bus.addressLinesOut}, 32'h0);
    checkVal("s4_rd1_mode", {30'd0, bus.memReadWrite}, 32'd0);
    waitDone("s4_done");

    // Abort during the first read of four.
    launch(24'h000050, 24'h000600, 16'd4);
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checkVal("s5_aborted", {31'd0, aborted}, 32'd1);
    checkVal("s5_busy", {31'd0, busy}, 32'd0);
    checkIdle("s5_bus");
    for (int k = 0; k < 4; k++) begin
      cyc();
      checkVal("s5_no_write", {30'd0, bus.memReadWrite}, 32'd3);
      checkVal("s5_no_done", {31'd0, done}, 32'd0);
    end
    checkVal("s5_pulse", {31'd0, aborted}, 32'd0);

    // Abort on the final write wins over completion.
    launch(24'h000020, 24'h000700, 16'd1);
    cyc();
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checkVal("s6_aborted", {31'd0, aborted}, 32'd1);
    cyc();
    checkVal("s6_no_done", {31'd0, done}, 32'd0);

    // Start while busy is ignored, then reset cancels the transfer.
    launch(24'h000700, 24'h000800, 16'd4);
    cyc();
    srcAddr = 24'h000900; dstAddr = 24'h000A00; length = 16'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    checkVal("s7_wr_addr", {8'd0, bus.addressLinesOut}, 32'h0800);
    cyc();
    checkVal("s7_rd_addr", {8'd0, bus.addressLinesOut}, 32'h0701);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checkIdle("s7_rst");
    checkVal("s7_rst_addr", {8'd0, bus.addressLinesOut}, 32'd0);
    checkVal("s7_rst_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      checkVal("s7_no_done", {30'd0, done, aborted}, 32'd0);
      checkVal("s7_idle_req", {31'd0, bus.busReq}, 32'd0);
    end

    // Abort coincident with start in IDLE is ignored; the start proceeds.
    srcAddr = 24'h000030; dstAddr = 24'h000900; length = 16'd1;
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    checkVal("s8_busy", {31'd0, busy}, 32'd1);
    checkVal("s8_no_abort", {31'd0, aborted}, 32'd0);
    waitDone("s8_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
